// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the traffic-signal controllers.
//   - LT_*          : one-hot lamp codes per approach (RED=001, YELLOW=010, GREEN=100, OFF=000)
//   - phase_state_t : controller state; 3-bit so out-of-range codes are detectable
//   - max4()        : helper to size counters from duration parameters
//   - lamp_decode() : per-approach lamp code from controller state
package traffic_pkg;

  localparam logic [2:0] LT_OFF    = 3'b000;
  localparam logic [2:0] LT_RED    = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b100;

  typedef enum logic [2:0] {
    S_GREEN   = 3'd0,
    S_YELLOW  = 3'd1,
    S_ALL_RED = 3'd2,
    S_FLASH   = 3'd3
  } phase_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Lamp for one approach. Anything not explicitly a green/yellow/flash-off
  // condition falls back to RED, including corrupted state codes.
  function automatic logic [2:0] lamp_decode(input phase_state_t st,
                                             input logic is_cur,
                                             input logic flash_on);
    logic [2:0] l;
    l = LT_RED;
    case (st)
      S_GREEN:  l = is_cur ? LT_GREEN  : LT_RED;
      S_YELLOW: l = is_cur ? LT_YELLOW : LT_RED;
      S_FLASH:  l = flash_on ? LT_RED : LT_OFF;
      default:  l = LT_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/rr_phase_pick.sv
// rr_phase_pick: combinational round-robin picker.
//   pending_i : request vector
//   cur_i     : last-served index; search starts at cur_i+1 (mod NUM_PHASES)
//   pick_o    : first set request found (valid only when found_o)
//   found_o   : any request set
module rr_phase_pick #(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] pending_i,
  input  logic [PH_W-1:0]       cur_i,
  output logic [PH_W-1:0]       pick_o,
  output logic                  found_o
);

  // Walk from the farthest offset to the nearest so the nearest set bit
  // is the last write and therefore wins.
  always_comb begin
    int idx;
    idx     = 0;
    found_o = 1'b0;
    pick_o  = '0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = (int'(cur_i) + k) % NUM_PHASES;
      if (pending_i[idx]) begin
        found_o = 1'b1;
        pick_o  = PH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase traffic-signal controller with internal phase
// timers, demand-driven phase skipping and flash (maintenance) mode.
//   clk, rst    : clock, synchronous active-high reset
//   demand      : per-phase request (level or pulse), latched into pending
//   flash_req   : level request for flash mode
//   lights      : lamp per phase, lights[3*i +: 3], one-hot R/Y/G or OFF
//   cur_phase   : phase currently or last served
//   phase_start : pulse on the first green cycle of a phase
//   in_flash    : high while flashing
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES     = 4,
  parameter int GREEN_CYCLES   = 16,
  parameter int YELLOW_CYCLES  = 4,
  parameter int ALL_RED_CYCLES = 2,
  parameter int FLASH_CYCLES   = 8,
  localparam int MAX_DUR = max4(GREEN_CYCLES, YELLOW_CYCLES, ALL_RED_CYCLES, FLASH_CYCLES),
  localparam int CNT_W   = $clog2(MAX_DUR) + 1,
  localparam int PH_W    = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PHASES-1:0]   demand,
  input  logic                    flash_req,
  output logic [NUM_PHASES*3-1:0] lights,
  output logic [PH_W-1:0]         cur_phase,
  output logic                    phase_start,
  output logic                    in_flash
);

  localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LD = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] F_LD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [PH_W-1:0]  LAST = PH_W'(NUM_PHASES - 1);

  phase_state_t            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PH_W-1:0]         cur_q, cur_d;
  logic [NUM_PHASES-1:0]   pend_q, pend_d;
  logic                    flash_ph_q, flash_ph_d;

  logic [PH_W-1:0]         rr_pick;
  logic                    rr_found;
  logic [PH_W-1:0]         rot_next;
  logic [PH_W-1:0]         next_phase;
  logic                    cnt_zero;

  rr_phase_pick #(
    .NUM_PHASES (NUM_PHASES),
    .PH_W       (PH_W)
  ) u_pick (
    .pending_i (pend_q),
    .cur_i     (cur_q),
    .pick_o    (rr_pick),
    .found_o   (rr_found)
  );

  // No demand anywhere: plain fixed-time rotation.
  assign rot_next   = (cur_q == LAST) ? '0 : cur_q + 1'b1;
  assign next_phase = rr_found ? rr_pick : rot_next;
  assign cnt_zero   = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q | demand;
    flash_ph_d = flash_ph_q;
    case (state_q)
      S_GREEN: begin
        // Flash request truncates green; flash itself waits for all-red.
        if (flash_req || cnt_zero) begin
          state_d = S_YELLOW;
          cnt_d   = Y_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_YELLOW: begin
        if (cnt_zero) begin
          state_d = S_ALL_RED;
          cnt_d   = R_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ALL_RED: begin
        if (cnt_zero) begin
          if (flash_req) begin
            state_d    = S_FLASH;
            cnt_d      = F_LD;
            flash_ph_d = 1'b1;
          end else begin
            state_d = S_GREEN;
            cnt_d   = G_LD;
            cur_d   = next_phase;
            // Clearing after the OR absorbs a same-cycle demand for the
            // phase being granted.
            pend_d[next_phase] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FLASH: begin
        if (!flash_req) begin
          state_d = S_ALL_RED;
          cnt_d   = R_LD;
        end else if (cnt_zero) begin
          flash_ph_d = ~flash_ph_q;
          cnt_d      = F_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_ALL_RED;
        cnt_d   = R_LD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ALL_RED;
      cnt_q      <= R_LD;
      cur_q      <= LAST;
      pend_q     <= '0;
      flash_ph_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      flash_ph_q <= flash_ph_d;
    end
  end

  // Outputs decode straight from registered state: no added latency.
  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_lamp
    assign lights[3*g +: 3] = lamp_decode(state_q, cur_q == PH_W'(g), flash_ph_q);
  end

  assign cur_phase   = cur_q;
  // Green always loads G_LD on entry, so cnt==G_LD marks only its first cycle.
  assign phase_start = (state_q == S_GREEN) && (cnt_q == G_LD);
  assign in_flash    = (state_q == S_FLASH);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

  localparam logic [2:0]  RD = 3'b001;
  localparam logic [2:0]  YL = 3'b010;
  localparam logic [2:0]  GR = 3'b100;
  localparam logic [11:0] ALLRED = 12'b001_001_001_001;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  demand;
  logic        flash_req;
  logic [11:0] lights;
  logic [1:0]  cur_phase;
  logic        phase_start;
  logic        in_flash;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .NUM_PHASES     (4),
    .GREEN_CYCLES   (5),
    .YELLOW_CYCLES  (2),
    .ALL_RED_CYCLES (1),
    .FLASH_CYCLES   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .demand      (demand),
    .flash_req   (flash_req),
    .lights      (lights),
    .cur_phase   (cur_phase),
    .phase_start (phase_start),
    .in_flash    (in_flash)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cyc%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  function automatic logic [11:0] lamps(input int p, input logic [2:0] code);
    logic [11:0] v;
    v = ALLRED;
    v[3*p +: 3] = code;
    return v;
  endfunction

  task automatic chk_start(input int ph);
    chk("phase_start", 32'(phase_start), 32'd1);
    chk("cur_phase", 32'(cur_phase), 32'(ph));
    chk("lights_green", 32'(lights), 32'(lamps(ph, GR)));
  endtask

  initial begin
    int ph, off;
    logic [11:0] exp_l;
    rst = 1'b1; demand = '0; flash_req = 1'b0;
    step(); step();
    chk("rst_lights", 32'(lights), 32'(ALLRED));
    chk("rst_cur", 32'(cur_phase), 32'd3);
    chk("rst_ps", 32'(phase_start), 32'd0);
    chk("rst_flash", 32'(in_flash), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Fixed-time rotation, period 8: G=5 Y=2 R=1.
    for (int c = 1; c <= 34; c++) begin
      step();
      ph  = ((c - 1) / 8) % 4;
      off = (c - 1) % 8;
      exp_l = (off < 5) ? lamps(ph, GR) : (off < 7) ? lamps(ph, YL) : ALLRED;
      chk("rot_lights", 32'(lights), 32'(exp_l));
      chk("rot_ps", 32'(phase_start), 32'(off == 0));
      chk("rot_cur", 32'(cur_phase), 32'(ph));
      chk("rot_flash", 32'(in_flash), 32'd0);
    end

    // demand[2] during phase 0 green skips phase 1; served once.
    demand = 4'b0100; step(); demand = '0;
    run_to(41); chk_start(2);
    run_to(49); chk_start(3);

    // demand 1 and 3 during phase 0 green: serve 1, then 3, then rotate.
    run_to(57); chk_start(0);
    run_to(58); demand = 4'b1010; step(); demand = '0;
    run_to(65); chk_start(1);
    run_to(73); chk_start(3);
    run_to(81); chk_start(0);

    // Flash on second green cycle of phase 0.
    run_to(82);
    chk("fl_pre_green", 32'(lights), 32'(lamps(0, GR)));
    flash_req = 1'b1;
    step(); chk("fl_trunc_yel", 32'(lights), 32'(lamps(0, YL)));
    step(); chk("fl_yel2", 32'(lights), 32'(lamps(0, YL)));
    step(); chk("fl_allred", 32'(lights), 32'(ALLRED));
    chk("fl_not_yet", 32'(in_flash), 32'd0);
    step(); chk("fl_on_red", 32'(lights), 32'(ALLRED));
    chk("fl_in_flash", 32'(in_flash), 32'd1);
    run_to(88); chk("fl_red3", 32'(lights), 32'(ALLRED));
    step(); chk("fl_off1", 32'(lights), 32'd0);
    run_to(91); chk("fl_off3", 32'(lights), 32'd0);
    chk("fl_ps", 32'(phase_start), 32'd0);
    step(); chk("fl_red_again", 32'(lights), 32'(ALLRED));
    flash_req = 1'b0;
    step(); chk("fl_exit_red", 32'(lights), 32'(ALLRED));
    chk("fl_exit_flag", 32'(in_flash), 32'd0);
    step(); chk_start(1);

    // Reset during phase 2 yellow clears pending demand for phase 2.
    run_to(102); chk_start(2);
    run_to(104); demand = 4'b0100; step(); demand = '0;
    run_to(107); chk("rs_yellow", 32'(lights), 32'(lamps(2, YL)));
    rst = 1'b1;
    step();
    chk("rs_lights", 32'(lights), 32'(ALLRED));
    chk("rs_cur", 32'(cur_phase), 32'd3);
    chk("rs_ps", 32'(phase_start), 32'd0);
    rst = 1'b0;
    step(); chk_start(0);
    run_to(117); chk_start(1);

    // demand[0] on the all-red cycle that grants phase 0 is absorbed.
    run_to(133); chk_start(3);
    run_to(140); chk("abs_allred", 32'(lights), 32'(ALLRED));
    demand = 4'b0001; step(); demand = '0;
    chk_start(0);
    run_to(149); chk_start(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
